// File: rtl/key_debounce_repeat_if.sv
// Key-path bundle between the pushbutton front end and the game FSM.
// Latency: none, this is wiring only.
// Backpressure: none, because every output is a single-cycle pulse or a level.
// Ports:
//   tick_input  : 100 Hz sample strobe, one CLOCK_50 cycle wide.
//   key_n       : raw active-low pushbuttons.
//   level       : debounced key state, 1 = pressed.
//   press_pulse : one-cycle pulse for each accepted press.
//   move_pulse  : press pulse OR auto-repeat pulse.
interface key_debounce_repeat_if #(
  parameter int N_KEYS = 4
);
  logic              tick_input;
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] move_pulse;

  // The master drives the strobe and the keys, and observes the results.
  modport master (
    output tick_input, key_n,
    input  level, press_pulse, move_pulse
  );

  // The debouncer side.
  modport slave (
    input  tick_input, key_n,
    output level, press_pulse, move_pulse
  );
endinterface

// File: rtl/key_debounce_repeat.sv
// Pushbutton synchroniser, tick-based debouncer and per-key auto-repeat generator.
// Latency: 2 sync flops, then STABLE_TICKS ticks to accept a level; pulses register on that edge.
// Backpressure: none. The pulses are fire-and-forget and the consumer must take them on the cycle they occur.
// Ports:
//   CLOCK_50 : system clock.
//   resetn   : asynchronous active-low reset.
//   bus      : slave side of key_debounce_repeat_if (tick_input, key_n in; level, press_pulse, move_pulse out).
module key_debounce_repeat #(
  parameter int                N_KEYS        = 4,
  parameter int                STABLE_TICKS  = 2,
  parameter int                REPEAT_DELAY  = 20,
  parameter int                REPEAT_PERIOD = 5,
  parameter logic [N_KEYS-1:0] REPEAT_MASK   = 4'b0111
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  key_debounce_repeat_if.slave bus
);

  localparam int DCNT_W = $clog2(STABLE_TICKS + 1);
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W = $clog2(RMAX + 1);

  localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(STABLE_TICKS);
  localparam logic [RCNT_W-1:0] RCNT_DELAY = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] RCNT_PER   = RCNT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Two-flop synchroniser. Its reset value is "released", so a key that is
  // held through reset is still seen as a fresh press once reset lifts.
  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] w_s;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bus.key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = ~r_sync2;

  logic [N_KEYS-1:0] w_level;
  logic [N_KEYS-1:0] w_press;
  logic [N_KEYS-1:0] w_move;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    logic              r_level;
    logic              r_press;
    logic              r_move;
    logic [DCNT_W-1:0] r_dcnt;
    logic [RCNT_W-1:0] r_rcnt;
    state_t            r_state;

    logic              w_level_nxt;
    logic [DCNT_W-1:0] w_dcnt_nxt;
    logic [RCNT_W-1:0] w_rcnt_nxt;
    logic [RCNT_W-1:0] w_rinc;
    state_t            w_state_nxt;
    logic              w_rise;
    logic              w_fall;
    logic              w_rep;

    // Debounce. A sample that matches the current level clears the run, so
    // only STABLE_TICKS consecutive disagreeing ticks flip the level.
    always_comb begin
      w_level_nxt = r_level;
      w_dcnt_nxt  = r_dcnt;
      if (bus.tick_input) begin
        if (w_s[gi] == r_level) begin
          w_dcnt_nxt = '0;
        end else if (r_dcnt + DCNT_W'(1) == DCNT_LAST) begin
          w_level_nxt = w_s[gi];
          w_dcnt_nxt  = '0;
        end else begin
          w_dcnt_nxt = r_dcnt + DCNT_W'(1);
        end
      end
    end

    assign w_rise = w_level_nxt & ~r_level;
    assign w_fall = ~w_level_nxt & r_level;
    assign w_rinc = r_rcnt + RCNT_W'(1);

    // Repeat FSM. A release is checked before anything else, so a release
    // that lands on a repeat boundary suppresses that repeat. A rise can
    // only happen in IDLE, so a press and a repeat never coincide.
    always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      w_rep       = 1'b0;
      if (!REPEAT_MASK[gi]) begin
        w_state_nxt = ST_IDLE;
        w_rcnt_nxt  = '0;
      end else if (w_fall) begin
        w_state_nxt = ST_IDLE;
        w_rcnt_nxt  = '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              w_state_nxt = ST_HOLD;
              w_rcnt_nxt  = '0;
            end
          end
          ST_HOLD: begin
            if (bus.tick_input && r_level) begin
              if (w_rinc == RCNT_DELAY) begin
                w_rep       = 1'b1;
                w_rcnt_nxt  = '0;
                w_state_nxt = ST_REPEAT;
              end else begin
                w_rcnt_nxt = w_rinc;
              end
            end
          end
          ST_REPEAT: begin
            if (bus.tick_input && r_level) begin
              if (w_rinc == RCNT_PER) begin
                w_rep      = 1'b1;
                w_rcnt_nxt = '0;
              end else begin
                w_rcnt_nxt = w_rinc;
              end
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_rcnt_nxt  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        r_level <= 1'b0;
        r_press <= 1'b0;
        r_move  <= 1'b0;
        r_dcnt  <= '0;
        r_rcnt  <= '0;
        r_state <= ST_IDLE;
      end else begin
        r_level <= w_level_nxt;
        r_press <= w_rise;
        r_move  <= w_rise | w_rep;
        r_dcnt  <= w_dcnt_nxt;
        r_rcnt  <= w_rcnt_nxt;
        r_state <= w_state_nxt;
      end
    end

    assign w_level[gi] = r_level;
    assign w_press[gi] = r_press;
    assign w_move[gi]  = r_move;
  end

  assign bus.level       = w_level;
  assign bus.press_pulse = w_press;
  assign bus.move_pulse  = w_move;

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Directed bench for key_debounce_repeat: debounce, press/repeat timing, release priority, async reset.
// Latency: the checks are taken 1 time unit after the tick edge on which an output is expected.
// Backpressure: none. A negedge monitor tallies pulses for the count-based checks.
module tb_key_debounce_repeat;

  logic clk;
  logic resetn;

  key_debounce_repeat_if #(.N_KEYS(4)) bus ();

  key_debounce_repeat #(
    .N_KEYS       (4),
    .STABLE_TICKS (2),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(5),
    .REPEAT_MASK  (4'b0111)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_no = 0;
  int cnt_press [4];
  int cnt_move  [4];
  int seen_lvl  [4];
  int mv_tick0  [8];
  int n_mv0;

  // Pulse monitor: samples mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.press_pulse[i]) cnt_press[i] = cnt_press[i] + 1;
        if (bus.move_pulse[i])  cnt_move[i]  = cnt_move[i] + 1;
        if (bus.level[i])       seen_lvl[i]  = 1;
      end
      if (bus.move_pulse[0] && n_mv0 < 8) begin
        mv_tick0[n_mv0] = tick_no;
        n_mv0 = n_mv0 + 1;
      end
    end
  end

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      cnt_press[i] = 0;
      cnt_move[i]  = 0;
      seen_lvl[i]  = 0;
    end
    for (int i = 0; i < 8; i++) mv_tick0[i] = -1;
    n_mv0   = 0;
    tick_no = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // One tick edge. The caller is left 1 time unit after that edge.
  task automatic tick_edge();
    tick_no++;
    bus.tick_input = 1'b1;
    step();
    bus.tick_input = 1'b0;
  endtask

  task automatic tick_gap();
    idle(9);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_edge();
      tick_gap();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn         = 1'b0;
    bus.tick_input = 1'b0;
    bus.key_n      = 4'hF;
    clear_counts();

    // Reset state.
    idle(2);
    check("rst_level", 32'(bus.level), 0);
    check("rst_press", 32'(bus.press_pulse), 0);
    check("rst_move",  32'(bus.move_pulse), 0);
    resetn = 1'b1;
    idle(2);

    // Clean press on key 0, held for 30 ticks.
    clear_counts();
    bus.key_n = 4'b1110;
    idle(2);
    tick_edge();
    check("clean_lvl_t1", 32'(bus.level), 0);
    tick_gap();
    tick_edge();
    check("clean_lvl_t2",   32'(bus.level), 1);
    check("clean_press_t2", 32'(bus.press_pulse), 1);
    check("clean_move_t2",  32'(bus.move_pulse), 1);
    tick_gap();
    check("clean_press_1cyc", 32'(bus.press_pulse), 0);
    ticks(28);
    bus.key_n = 4'hF;
    idle(2);
    ticks(2);
    check("clean_released", 32'(bus.level), 0);
    ticks(10);
    check("clean_npress", cnt_press[0], 1);
    check("clean_nmove",  cnt_move[0], 3);
    check("clean_mv0",    mv_tick0[0], 2);
    check("clean_mv1",    mv_tick0[1], 22);
    check("clean_mv2",    mv_tick0[2], 27);

    // Bounce on key 1: alternating ticks must never be accepted.
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      bus.key_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      idle(2);
      ticks(1);
    end
    bus.key_n = 4'hF;
    idle(2);
    ticks(5);
    check("bounce_level", seen_lvl[1], 0);
    check("bounce_press", cnt_press[1], 0);
    check("bounce_move",  cnt_move[1], 0);

    // Rotate key 3 has no auto-repeat.
    clear_counts();
    bus.key_n = 4'b0111;
    idle(2);
    ticks(50);
    check("rot_level", 32'(bus.level), 32'h8);
    check("rot_press", cnt_press[3], 1);
    check("rot_move",  cnt_move[3], 1);
    bus.key_n = 4'hF;
    idle(2);
    ticks(3);
    check("rot_released", 32'(bus.level), 0);

    // Key 2: the release lands on the first repeat boundary (tick 22).
    clear_counts();
    bus.key_n = 4'b1011;
    idle(2);
    ticks(20);
    bus.key_n = 4'hF;
    idle(2);
    tick_edge();
    check("bnd_lvl_t21", 32'(bus.level), 32'h4);
    tick_gap();
    tick_edge();
    check("bnd_lvl_t22",  32'(bus.level), 0);
    check("bnd_move_t22", 32'(bus.move_pulse), 0);
    tick_gap();
    ticks(10);
    check("bnd_press", cnt_press[2], 1);
    check("bnd_move",  cnt_move[2], 1);
    // A new press must time its first repeat from zero, which shows the FSM went back to IDLE.
    clear_counts();
    bus.key_n = 4'b1011;
    idle(2);
    ticks(21);
    check("bnd_re_move_t21", cnt_move[2], 1);
    tick_edge();
    check("bnd_re_rep_t22",   32'(bus.move_pulse), 32'h4);
    check("bnd_re_press_t22", 32'(bus.press_pulse), 0);
    tick_gap();
    check("bnd_re_nmove", cnt_move[2], 2);
    bus.key_n = 4'hF;
    idle(2);
    ticks(3);

    // Asynchronous reset in REPEAT, asserted between edges.
    clear_counts();
    bus.key_n = 4'b1110;
    idle(2);
    ticks(26);
    tick_edge();
    check("arst_pre_move", 32'(bus.move_pulse), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_level", 32'(bus.level), 0);
    check("arst_press", 32'(bus.press_pulse), 0);
    check("arst_move",  32'(bus.move_pulse), 0);
    step();
    step();
    resetn = 1'b1;
    clear_counts();
    idle(2);
    tick_edge();
    check("arst_t1_press", 32'(bus.press_pulse), 0);
    tick_gap();
    tick_edge();
    check("arst_t2_press", 32'(bus.press_pulse), 1);
    tick_gap();
    bus.key_n = 4'hF;
    idle(2);
    ticks(3);

    // Simultaneous presses on keys 0 and 1.
    clear_counts();
    bus.key_n = 4'b1100;
    idle(2);
    tick_edge();
    check("sim_press_t1", 32'(bus.press_pulse), 0);
    tick_gap();
    tick_edge();
    check("sim_press_t2", 32'(bus.press_pulse), 32'h3);
    check("sim_move_t2",  32'(bus.move_pulse), 32'h3);
    tick_gap();
    ticks(19);
    tick_edge();
    check("sim_rep_t22", 32'(bus.move_pulse), 32'h3);
    tick_gap();
    ticks(4);
    tick_edge();
    check("sim_rep_t27", 32'(bus.move_pulse), 32'h3);
    tick_gap();
    check("sim_nmove0",  cnt_move[0], 3);
    check("sim_nmove1",  cnt_move[1], 3);
    check("sim_npress0", cnt_press[0], 1);
    bus.key_n = 4'hF;
    idle(2);
    ticks(3);
    check("sim_released", 32'(bus.level), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
